// File: rtl/serial_digit_sub.sv
`timescale 1ns/1ps
// Digit-serial subtractor: a - b - bin over WIDTH bits, DIGIT bits per cycle, LSB first,
// with optional magnitude-plus-sign result for the floating-point datapath.
module serial_digit_sub #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    input  logic             mode,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             neg,
    output logic             zero
);

    localparam int unsigned N     = WIDTH / DIGIT;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, NEG, DONE} state_t;

    state_t             state_q, state_n;
    logic [WIDTH-1:0]   a_q, a_n, b_q, b_n;
    logic [WIDTH-1:0]   diff_q, diff_n;
    logic [CNT_W-1:0]   count_q, count_n;
    logic               borrow_q, borrow_n, mode_q, mode_n;
    logic               bout_q, bout_n, neg_q, neg_n, zero_q, zero_n;
    logic               busy_q, busy_n, done_q, done_n;

    logic [DIGIT-1:0]   a_dig, b_dig, d_dig;
    logic               br_chain;

    // Operands shift right each RUN cycle so the current digit is always at the bottom.
    assign a_dig = a_q[DIGIT-1:0];
    assign b_dig = b_q[DIGIT-1:0];

    // Ripple-borrow full-subtract chain across one digit.
    always_comb begin
        d_dig    = '0;
        br_chain = borrow_q;
        for (int i = 0; i < int'(DIGIT); i++) begin
            d_dig[i] = a_dig[i] ^ b_dig[i] ^ br_chain;
            br_chain = (~a_dig[i] & b_dig[i]) | (~(a_dig[i] ^ b_dig[i]) & br_chain);
        end
    end

    always_comb begin
        state_n  = state_q;
        a_n      = a_q;
        b_n      = b_q;
        diff_n   = diff_q;
        count_n  = count_q;
        borrow_n = borrow_q;
        mode_n   = mode_q;
        bout_n   = bout_q;
        neg_n    = neg_q;
        zero_n   = zero_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_n      = a;
                    b_n      = b;
                    borrow_n = bin;
                    mode_n   = mode;
                    count_n  = '0;
                    diff_n   = '0;
                    bout_n   = 1'b0;
                    neg_n    = 1'b0;
                    zero_n   = 1'b0;
                    state_n  = RUN;
                end
            end
            RUN: begin
                // diff is cleared on accept, so OR-ing each digit into place is sufficient.
                diff_n   = diff_q | (WIDTH'(d_dig) << (count_q * DIGIT));
                a_n      = a_q >> DIGIT;
                b_n      = b_q >> DIGIT;
                borrow_n = br_chain;
                count_n  = count_q + CNT_W'(1);
                if (count_q == LAST) begin
                    bout_n  = br_chain;
                    state_n = (mode_q && br_chain) ? NEG : DONE;
                end
            end
            NEG: begin
                diff_n  = ~diff_q + WIDTH'(1);
                neg_n   = 1'b1;
                state_n = DONE;
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (state_n == DONE) begin
            zero_n = (diff_n == '0);
        end
        done_n = (state_n == DONE);
        busy_n = (state_n == RUN) || (state_n == NEG);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            count_q  <= '0;
            borrow_q <= 1'b0;
            mode_q   <= 1'b0;
            bout_q   <= 1'b0;
            neg_q    <= 1'b0;
            zero_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_n;
            a_q      <= a_n;
            b_q      <= b_n;
            diff_q   <= diff_n;
            count_q  <= count_n;
            borrow_q <= borrow_n;
            mode_q   <= mode_n;
            bout_q   <= bout_n;
            neg_q    <= neg_n;
            zero_q   <= zero_n;
            busy_q   <= busy_n;
            done_q   <= done_n;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;
    assign neg  = neg_q;
    assign zero = zero_q;

endmodule

// File: tb/tb_serial_digit_sub.sv
`timescale 1ns/1ps
// Scoreboard bench for serial_digit_sub: an 8/4 instance for most vectors, a 24/4 instance
// for the default geometry; expected results are queued at issue and checked on done.
module tb_serial_digit_sub;

    typedef struct {
        logic [23:0] diff;
        logic        bout;
        logic        neg;
        logic        zero;
        int          lat;
        int          bsy;
        int          stamp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start8 = 1'b0, bin8 = 1'b0, mode8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8, bout8, neg8, zero8;
    logic [7:0]  diff8;

    logic        start24 = 1'b0, bin24 = 1'b0, mode24 = 1'b0;
    logic [23:0] a24 = '0, b24 = '0;
    logic        busy24, done24, bout24, neg24, zero24;
    logic [23:0] diff24;

    int   cyc = 0;
    int   total = 0;
    int   passes = 0;
    int   busy8_cnt = 0;
    int   busy24_cnt = 0;
    exp_t q8[$];
    exp_t q24[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_digit_sub #(.WIDTH(8), .DIGIT(4)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8), .mode(mode8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .neg(neg8), .zero(zero8)
    );

    serial_digit_sub #(.WIDTH(24), .DIGIT(4)) dut24 (
        .clk(clk), .rst(rst), .start(start24), .a(a24), .b(b24), .bin(bin24), .mode(mode24),
        .busy(busy24), .done(done24), .diff(diff24), .bout(bout24), .neg(neg24), .zero(zero24)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            passes++;
        end
    endtask

    // Monitors: pop and compare whenever a DUT pulses done.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            busy8_cnt = 0;
        end else begin
            if (busy8) busy8_cnt++;
            if (done8) begin
                if (q8.size() == 0) begin
                    chk("unexpected_done8", 1, 0);
                end else begin
                    e = q8.pop_front();
                    chk("diff8", longint'(diff8), longint'(e.diff[7:0]));
                    chk("bout8", longint'(bout8), longint'(e.bout));
                    chk("neg8", longint'(neg8), longint'(e.neg));
                    chk("zero8", longint'(zero8), longint'(e.zero));
                    chk("lat8", longint'(cyc - e.stamp), longint'(e.lat));
                    chk("busy8_cycles", longint'(busy8_cnt), longint'(e.bsy));
                end
                busy8_cnt = 0;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            busy24_cnt = 0;
        end else begin
            if (busy24) busy24_cnt++;
            if (done24) begin
                if (q24.size() == 0) begin
                    chk("unexpected_done24", 1, 0);
                end else begin
                    e = q24.pop_front();
                    chk("diff24", longint'(diff24), longint'(e.diff));
                    chk("bout24", longint'(bout24), longint'(e.bout));
                    chk("neg24", longint'(neg24), longint'(e.neg));
                    chk("zero24", longint'(zero24), longint'(e.zero));
                    chk("lat24", longint'(cyc - e.stamp), longint'(e.lat));
                    chk("busy24_cycles", longint'(busy24_cnt), longint'(e.bsy));
                end
                busy24_cnt = 0;
            end
        end
    end

    task automatic issue8(input logic [7:0] ta, input logic [7:0] tb_, input logic tbin,
                          input logic tmode, input logic [7:0] ediff, input logic ebout,
                          input logic eneg, input logic ezero, input int elat, input int ebsy);
        exp_t e;
        @(negedge clk);
        a8 = ta; b8 = tb_; bin8 = tbin; mode8 = tmode; start8 = 1'b1;
        e.diff = 24'(ediff); e.bout = ebout; e.neg = eneg; e.zero = ezero;
        e.lat = elat; e.bsy = ebsy; e.stamp = cyc;
        q8.push_back(e);
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while ((q8.size() != 0 || q24.size() != 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk(nm, longint'(q8.size() + q24.size()), 0);
    endtask

    initial begin
        exp_t e;
        int   n;

        #2;
        chk("rst_busy", longint'(busy8), 0);
        chk("rst_done", longint'(done8), 0);
        chk("rst_diff", longint'(diff8), 0);
        chk("rst_flags", longint'({bout8, neg8, zero8}), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        issue8(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h1E, 1'b0, 1'b0, 1'b0, 3, 2);
        drain("drain_basic");
        issue8(8'h3C, 8'h5A, 1'b0, 1'b0, 8'hE2, 1'b1, 1'b0, 1'b0, 3, 2);
        drain("drain_raw_neg");
        issue8(8'h3C, 8'h5A, 1'b0, 1'b1, 8'h1E, 1'b1, 1'b1, 1'b0, 4, 3);
        drain("drain_mag_neg");
        issue8(8'h80, 8'h80, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 3, 2);
        drain("drain_mag_zero");
        issue8(8'h80, 8'h80, 1'b1, 1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 4, 3);
        drain("drain_mag_bin");
        issue8(8'h00, 8'hFF, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 4, 3);
        drain("drain_corner");
        issue8(8'h00, 8'h00, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 3, 2);
        drain("drain_bin_raw");

        // Default geometry on the 24-bit instance.
        @(negedge clk);
        a24 = 24'h000001; b24 = 24'h800000; bin24 = 1'b0; mode24 = 1'b1; start24 = 1'b1;
        e.diff = 24'h7FFFFF; e.bout = 1'b1; e.neg = 1'b1; e.zero = 1'b0;
        e.lat = 8; e.bsy = 7; e.stamp = cyc;
        q24.push_back(e);
        @(negedge clk);
        start24 = 1'b0;
        drain("drain_24");

        // Start during RUN is ignored; operands change too.
        issue8(8'hA5, 8'h25, 1'b0, 1'b0, 8'h80, 1'b0, 1'b0, 1'b0, 3, 2);
        a8 = 8'hFF; b8 = 8'h00; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        drain("drain_ignore_run");

        // Start during the DONE cycle is not accepted.
        issue8(8'h44, 8'h11, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0, 1'b0, 3, 2);
        n = 0;
        while (!done8 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("saw_done", longint'(done8), 1);
        a8 = 8'hFF; b8 = 8'h00; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        chk("ignore_done_busy", longint'(busy8), 0);
        chk("ignore_done_diff", longint'(diff8), 8'h33);

        // Asynchronous reset mid-RUN, between clock edges.
        @(negedge clk);
        a8 = 8'h5A; b8 = 8'h3C; bin8 = 1'b0; mode8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        chk("pre_rst_busy", longint'(busy8), 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_busy", longint'(busy8), 0);
        chk("mid_rst_done", longint'(done8), 0);
        chk("mid_rst_diff", longint'(diff8), 0);
        chk("mid_rst_flags", longint'({bout8, neg8, zero8}), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        issue8(8'h77, 8'h77, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3, 2);
        drain("drain_after_rst");

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", passes, total);
        $fatal(1);
    end

endmodule
